// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_pkg
// Brief    : Shared definitions for the serial sync-word frame transmitter and
//            the matching detector: FSM state encoding, sync word, helpers.
// Revision : 1.0  initial release
// ============================================================================
package seq_pkg;

  // Transmitter phase encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  // Sync word shared by both ends of the link so they cannot diverge
  localparam logic [3:0] SYNC_WORD = 4'b1011;

  // Counter width able to hold the longest phase length minus one
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = 2;
    if (a > m) m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_bit_counter.sv
`default_nettype none
// ============================================================================
// Module   : seq_bit_counter
// Brief    : Loadable down-counter with a zero flag and a look-ahead zero flag,
//            reused for the sync, payload and gap phases.
// Revision : 1.0  initial release
// ============================================================================
module seq_bit_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero,
  output logic         zero_next
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: load has priority; decrement saturates at zero so it never wraps
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign zero      = (count_q == '0);
  assign zero_next = (count_d == '0);

endmodule
`default_nettype wire

// File: rtl/seq_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : seq_frame_tx
// Brief    : Serial frame transmitter. Accepts a payload over valid/ready and
//            sends sync word + payload MSB first, followed by a zero idle gap.
// Revision : 1.0  initial release
// ============================================================================
module seq_frame_tx
  import seq_pkg::*;
#(
  parameter int                SYNC_W   = 4,
  parameter logic [SYNC_W-1:0] SYNC     = SYNC_W'(SYNC_WORD),
  parameter int                DATA_W   = 8,
  parameter int                GAP_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out,
  output logic              out_valid,
  output logic              busy,
  output logic              done
);

  localparam int SR_W     = SYNC_W + DATA_W;
  localparam int CNT_W    = cnt_width(SYNC_W, DATA_W, GAP_BITS);
  localparam int GAP_LOAD = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;

  localparam logic [CNT_W-1:0] SYNC_CNT = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_CNT  = CNT_W'(GAP_LOAD);

  state_e            state_q, state_d;
  logic [SR_W-1:0]   shift_q, shift_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_load_val;
  logic              cnt_dec;
  logic [CNT_W-1:0]  cnt_value;
  logic              cnt_zero;
  logic              cnt_zero_next;

  // Phase length counter shared by all three phases
  seq_bit_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .load      (cnt_load),
    .load_val  (cnt_load_val),
    .dec       (cnt_dec),
    .count     (cnt_value),
    .zero      (cnt_zero),
    .zero_next (cnt_zero_next)
  );

  // Next-state, shifter and counter control. The shifter fills with zeros, so
  // once sync and payload are out its MSB stays 0 through the gap and idle.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          shift_d      = {SYNC, in_data};
          state_d      = ST_SYNC;
          cnt_load     = 1'b1;
          cnt_load_val = SYNC_CNT;
        end
      end
      ST_SYNC: begin
        shift_d = {shift_q[SR_W-2:0], 1'b0};
        if (cnt_zero) begin
          state_d      = ST_DATA;
          cnt_load     = 1'b1;
          cnt_load_val = DATA_CNT;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DATA: begin
        shift_d = {shift_q[SR_W-2:0], 1'b0};
        if (cnt_zero) begin
          if (GAP_BITS > 0) begin
            state_d      = ST_GAP;
            cnt_load     = 1'b1;
            cnt_load_val = GAP_CNT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        shift_d  = '0;
        cnt_load = 1'b1;
      end
    endcase
  end

  // Registered status outputs, decoded from the upcoming state so they line up
  // with the bit leaving the shifter
  always_comb begin
    out_valid_d = (state_d == ST_SYNC) || (state_d == ST_DATA);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DATA) && cnt_zero_next;
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out       = shift_q[SR_W-1];
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign in_ready  = (state_q == ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_seq_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_frame_tx
// Brief    : Scoreboard bench for seq_frame_tx with a frame-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_seq_frame_tx;

  localparam int         DATA_W   = 8;
  localparam int         GAP_BITS = 2;
  localparam logic [3:0] TB_SYNC  = 4'b1011;
  localparam int         FRAME    = 4 + DATA_W + GAP_BITS;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              out;
  logic              out_valid;
  logic              busy;
  logic              done;

  exp_t sb[$];
  int   rem = 0;
  logic end_req = 1'b0;
  int   checks = 0;
  int   failures = 0;

  seq_frame_tx dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Reference model: an accepted payload occupies the line for FRAME cycles;
  // the sync word then the payload are queued MSB first, last bit flagged.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rem = 0;
      sb.delete();
    end else if (rem > 0) begin
      rem = rem - 1;
    end else if (in_valid === 1'b1) begin
      for (int i = 3; i >= 0; i--) sb.push_back('{b: TB_SYNC[i], last: 1'b0});
      for (int i = DATA_W - 1; i >= 0; i--) sb.push_back('{b: in_data[i], last: (i == 0)});
      rem = FRAME;
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Monitor: compares status every cycle and pops a bit whenever out_valid
  initial begin
    exp_t e;
    while (!end_req) begin
      @(negedge clk or posedge rst);
      #1;
      chk("in_ready", in_ready, rem == 0);
      chk("busy", busy, rem > 0);
      chk("out_valid", out_valid, rem > GAP_BITS);
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow at %0t: got out_valid=1 expected no pending bit", $time);
        end else begin
          e = sb.pop_front();
          chk("out_bit", out, e.b);
          chk("done", done, e.last);
        end
      end else begin
        chk("out_idle", out, 1'b0);
        chk("done_idle", done, 1'b0);
      end
    end
    chk("sb_empty", sb.size() == 0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [DATA_W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = DATA_W'($urandom);
  endtask

  // Stimulus
  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(10);

    send(8'hA5);
    idle(16);

    in_valid = 1'b1;
    in_data  = 8'h3C;
    repeat (45) begin
      @(posedge clk);
      #1;
    end
    idle(16);

    send(8'h00);
    idle(3);
    send(8'hFF);
    idle(20);

    send(8'h55);
    idle(5);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h81;
    @(posedge clk);
    #1;
    idle(16);

    repeat (300) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = DATA_W'($urandom);
      @(posedge clk);
      #1;
    end
    idle(20);
    end_req = 1'b1;
  end

endmodule
`default_nettype wire
